// File: rtl/ex_stage_if.sv
// ID/EX, WB and EX/MEM signal bundle for the MIPS execute stage.
// The stage uses the slave modport; the surrounding pipeline uses master.
interface ex_stage_if;
  logic [4:0]  ALUCode_ex;
  logic        ALUSrcA_ex;
  logic        ALUSrcB_ex;
  logic        RegDst_ex;
  logic        MemWrite_ex;
  logic        MemRead_ex;
  logic        RegWrite_ex;
  logic        MemToReg_ex;
  logic [31:0] Sa_ex;
  logic [31:0] Imm_ex;
  logic [4:0]  RsAddr_ex;
  logic [4:0]  RtAddr_ex;
  logic [4:0]  RdAddr_ex;
  logic [31:0] RsData_ex;
  logic [31:0] RtData_ex;
  logic        RegWrite_wb;
  logic [4:0]  WriteAddr_wb;
  logic [31:0] WriteData_wb;
  logic [31:0] ALUResult_mem;
  logic [31:0] MemWriteData_mem;
  logic [4:0]  WriteAddr_mem;
  logic        RegWrite_mem;
  logic        MemWrite_mem;
  logic        MemRead_mem;
  logic        MemToReg_mem;
  logic        ex_busy;

  modport slave (
    input  ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, RegDst_ex,
           MemWrite_ex, MemRead_ex, RegWrite_ex, MemToReg_ex,
           Sa_ex, Imm_ex, RsAddr_ex, RtAddr_ex, RdAddr_ex,
           RsData_ex, RtData_ex, RegWrite_wb, WriteAddr_wb, WriteData_wb,
    output ALUResult_mem, MemWriteData_mem, WriteAddr_mem,
           RegWrite_mem, MemWrite_mem, MemRead_mem, MemToReg_mem, ex_busy
  );

  modport master (
    output ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, RegDst_ex,
           MemWrite_ex, MemRead_ex, RegWrite_ex, MemToReg_ex,
           Sa_ex, Imm_ex, RsAddr_ex, RtAddr_ex, RdAddr_ex,
           RsData_ex, RtData_ex, RegWrite_wb, WriteAddr_wb, WriteData_wb,
    input  ALUResult_mem, MemWriteData_mem, WriteAddr_mem,
           RegWrite_mem, MemWrite_mem, MemRead_mem, MemToReg_mem, ex_busy
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, destination select and EX/MEM register.
// Define EX_MUL_EN to include the iterative shift-add multiplier (ALU code 16).
module ex_stage (
  input logic         clk,
  input logic         reset,
  ex_stage_if.slave   bus
);

  localparam logic [4:0] ALU_MUL = 5'd16;

  logic [31:0] aluResultMem;
  logic [31:0] memWriteDataMem;
  logic [4:0]  writeAddrMem;
  logic        regWriteMem;
  logic        memWriteMem;
  logic        memReadMem;
  logic        memToRegMem;
  logic        busy;

  logic [31:0] fwdRs, fwdRt;
  logic [31:0] opA, opB;
  logic [31:0] aluResult;
  logic [31:0] nextResult;
  logic [4:0]  writeAddr;

  // EX/MEM has priority over MEM/WB; r0 is never forwarded.
  always_comb begin
    fwdRs = bus.RsData_ex;
    if (regWriteMem && writeAddrMem != '0 && writeAddrMem == bus.RsAddr_ex)
      fwdRs = aluResultMem;
    else if (bus.RegWrite_wb && bus.WriteAddr_wb != '0 && bus.WriteAddr_wb == bus.RsAddr_ex)
      fwdRs = bus.WriteData_wb;
  end

  always_comb begin
    fwdRt = bus.RtData_ex;
    if (regWriteMem && writeAddrMem != '0 && writeAddrMem == bus.RtAddr_ex)
      fwdRt = aluResultMem;
    else if (bus.RegWrite_wb && bus.WriteAddr_wb != '0 && bus.WriteAddr_wb == bus.RtAddr_ex)
      fwdRt = bus.WriteData_wb;
  end

  assign opA       = bus.ALUSrcA_ex ? bus.Sa_ex : fwdRs;
  assign opB       = bus.ALUSrcB_ex ? bus.Imm_ex : fwdRt;
  assign writeAddr = bus.RegDst_ex ? bus.RdAddr_ex : bus.RtAddr_ex;

  always_comb begin
    aluResult = '0;
    case (bus.ALUCode_ex)
      5'd0:    aluResult = opA + opB;
      5'd1:    aluResult = opA - opB;
      5'd2:    aluResult = opA & opB;
      5'd3:    aluResult = opA | opB;
      5'd4:    aluResult = opA ^ opB;
      5'd5:    aluResult = ~(opA | opB);
      5'd6:    aluResult = {31'd0, $signed(opA) < $signed(opB)};
      5'd7:    aluResult = {31'd0, opA < opB};
      5'd8:    aluResult = opB << opA[4:0];
      5'd9:    aluResult = opB >> opA[4:0];
      5'd10:   aluResult = $unsigned($signed(opB) >>> opA[4:0]);
      5'd11:   aluResult = {opB[15:0], 16'd0};
      default: aluResult = '0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

  mulState_t   state, stateNext;
  logic [31:0] mulA, mulB, acc;
  logic [4:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (bus.ALUCode_ex == ALU_MUL) begin
              busy      = 1'b1;
              stateNext = BUSY;
            end
      BUSY: begin
              busy = 1'b1;
              if (cnt == 5'd31) stateNext = DONE;
            end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operands are latched on entry so later WB traffic cannot disturb them.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.ALUCode_ex == ALU_MUL) begin
      mulA <= opA;
      mulB <= opB;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      if (mulB[0]) acc <= acc + mulA;
      mulA <= mulA << 1;
      mulB <= mulB >> 1;
      cnt  <= cnt + 5'd1;
    end
  end

  assign nextResult = (state == DONE) ? acc : aluResult;
`else
  assign busy       = 1'b0;
  assign nextResult = aluResult;
`endif

  always_ff @(posedge clk) begin
    if (reset || busy) begin
      aluResultMem    <= '0;
      memWriteDataMem <= '0;
      writeAddrMem    <= '0;
      regWriteMem     <= 1'b0;
      memWriteMem     <= 1'b0;
      memReadMem      <= 1'b0;
      memToRegMem     <= 1'b0;
    end else begin
      aluResultMem    <= nextResult;
      memWriteDataMem <= fwdRt;
      writeAddrMem    <= writeAddr;
      regWriteMem     <= bus.RegWrite_ex;
      memWriteMem     <= bus.MemWrite_ex;
      memReadMem      <= bus.MemRead_ex;
      memToRegMem     <= bus.MemToReg_ex;
    end
  end

  assign bus.ALUResult_mem    = aluResultMem;
  assign bus.MemWriteData_mem = memWriteDataMem;
  assign bus.WriteAddr_mem    = writeAddrMem;
  assign bus.RegWrite_mem     = regWriteMem;
  assign bus.MemWrite_mem     = memWriteMem;
  assign bus.MemRead_mem      = memReadMem;
  assign bus.MemToReg_mem     = memToRegMem;
  assign bus.ex_busy          = busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage; multiplier checks follow EX_MUL_EN.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.ALUCode_ex   = '0;
    bus.ALUSrcA_ex   = 1'b0;
    bus.ALUSrcB_ex   = 1'b0;
    bus.RegDst_ex    = 1'b0;
    bus.MemWrite_ex  = 1'b0;
    bus.MemRead_ex   = 1'b0;
    bus.RegWrite_ex  = 1'b0;
    bus.MemToReg_ex  = 1'b0;
    bus.Sa_ex        = '0;
    bus.Imm_ex       = '0;
    bus.RsAddr_ex    = '0;
    bus.RtAddr_ex    = '0;
    bus.RdAddr_ex    = '0;
    bus.RsData_ex    = '0;
    bus.RtData_ex    = '0;
    bus.RegWrite_wb  = 1'b0;
    bus.WriteAddr_wb = '0;
    bus.WriteData_wb = '0;
  endtask

  // Rs from register data, B from immediate, no writeback: isolates ALU function.
  task automatic aluImm(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [31:0] exp);
    clearInputs();
    bus.ALUCode_ex = code;
    bus.RsAddr_ex  = 5'd7;
    bus.RsData_ex  = a;
    bus.ALUSrcB_ex = 1'b1;
    bus.Imm_ex     = b;
    step();
    checkVal(tag, bus.ALUResult_mem, exp);
  endtask

  initial begin
    int unsigned n;
    int unsigned bubbleErr;
    clearInputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checkVal("rstResult", bus.ALUResult_mem, 32'h0);
    checkVal("rstRegWrite", {31'd0, bus.RegWrite_mem}, 32'h0);
    checkVal("rstBusy", {31'd0, bus.ex_busy}, 32'h0);

    // ADD without hazards
    clearInputs();
    bus.RsAddr_ex = 5'd1; bus.RsData_ex = 32'd5;
    bus.RtAddr_ex = 5'd2; bus.RtData_ex = 32'd7;
    bus.RegDst_ex = 1'b1; bus.RdAddr_ex = 5'd3; bus.RegWrite_ex = 1'b1;
    step();
    checkVal("addResult", bus.ALUResult_mem, 32'd12);
    checkVal("addWaddr", {27'd0, bus.WriteAddr_mem}, 32'd3);
    checkVal("addRegWrite", {31'd0, bus.RegWrite_mem}, 32'd1);
    checkVal("addStoreData", bus.MemWriteData_mem, 32'd7);

    // Put r4=0x10 into EX/MEM
    clearInputs();
    bus.RsAddr_ex = 5'd5; bus.RsData_ex = 32'h10;
    bus.ALUSrcB_ex = 1'b1; bus.Imm_ex = 32'h0;
    bus.RegDst_ex = 1'b1; bus.RdAddr_ex = 5'd4; bus.RegWrite_ex = 1'b1;
    step();
    checkVal("setupFwd", bus.ALUResult_mem, 32'h10);

    // EX/MEM r4 beats MEM/WB r4 on both Rs and Rt
    clearInputs();
    bus.RegWrite_wb = 1'b1; bus.WriteAddr_wb = 5'd4; bus.WriteData_wb = 32'h20;
    bus.RsAddr_ex = 5'd4; bus.RtAddr_ex = 5'd4;
    bus.ALUSrcB_ex = 1'b1; bus.Imm_ex = 32'd1;
    bus.RegDst_ex = 1'b1; bus.RdAddr_ex = 5'd6; bus.RegWrite_ex = 1'b1;
    step();
    checkVal("fwdMemPrio", bus.ALUResult_mem, 32'h11);
    checkVal("fwdMemRt", bus.MemWriteData_mem, 32'h10);

    // EX/MEM now writes r6, so only MEM/WB matches r4
    bus.RdAddr_ex = 5'd8;
    step();
    checkVal("fwdWb", bus.ALUResult_mem, 32'h21);

    // EX/MEM and MEM/WB both target r0: no forwarding
    clearInputs();
    bus.RsAddr_ex = 5'd5; bus.RsData_ex = 32'h10;
    bus.ALUSrcB_ex = 1'b1;
    bus.RegDst_ex = 1'b1; bus.RdAddr_ex = 5'd0; bus.RegWrite_ex = 1'b1;
    step();
    clearInputs();
    bus.RegWrite_wb = 1'b1; bus.WriteAddr_wb = 5'd0; bus.WriteData_wb = 32'h20;
    bus.ALUSrcB_ex = 1'b1; bus.Imm_ex = 32'd1;
    step();
    checkVal("fwdR0", bus.ALUResult_mem, 32'd1);

    // SRA by shamt
    clearInputs();
    bus.ALUCode_ex = 5'd10;
    bus.ALUSrcA_ex = 1'b1; bus.Sa_ex = 32'd4;
    bus.ALUSrcB_ex = 1'b1; bus.Imm_ex = 32'h8000_0000;
    step();
    checkVal("sra", bus.ALUResult_mem, 32'hF800_0000);

    aluImm(5'd6,  32'hFFFF_FFFF, 32'd1,      "slt",  32'd1);
    aluImm(5'd7,  32'hFFFF_FFFF, 32'd1,      "sltu", 32'd0);
    aluImm(5'd1,  32'd5,         32'd7,      "sub",  32'hFFFF_FFFE);
    aluImm(5'd0,  32'hFFFF_FFFF, 32'd2,      "addWrap", 32'd1);
    aluImm(5'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, "and", 32'h00F0_1234);
    aluImm(5'd3,  32'hF000_0001, 32'h0000_0100, "or",  32'hF000_0101);
    aluImm(5'd4,  32'hFFFF_0000, 32'hF0F0_F0F0, "xor", 32'h0F0F_F0F0);
    aluImm(5'd5,  32'h0000_0000, 32'h0000_00FF, "nor", 32'hFFFF_FF00);
    aluImm(5'd8,  32'd8,         32'd1,      "sll",  32'h0000_0100);
    aluImm(5'd9,  32'd4,         32'h8000_0000, "srl", 32'h0800_0000);
    aluImm(5'd11, 32'd0,         32'h0000_1234, "lui", 32'h1234_0000);
    aluImm(5'd12, 32'd3,         32'd4,      "undef", 32'd0);

    // Control passthrough and RegDst=0 selects Rt
    clearInputs();
    bus.MemWrite_ex = 1'b1; bus.MemRead_ex = 1'b1; bus.MemToReg_ex = 1'b1;
    bus.RtAddr_ex = 5'd17; bus.RdAddr_ex = 5'd9; bus.RtData_ex = 32'hCAFE_0001;
    step();
    checkVal("ctrlBits", {28'd0, bus.RegWrite_mem, bus.MemWrite_mem, bus.MemRead_mem, bus.MemToReg_mem}, 32'h7);
    checkVal("rtDest", {27'd0, bus.WriteAddr_mem}, 32'd17);
    checkVal("storeData", bus.MemWriteData_mem, 32'hCAFE_0001);

`ifdef EX_MUL_EN
    // 0xFFFF x 0x10001: 33 busy cycles with bubbles, then the product
    clearInputs();
    bus.ALUCode_ex = 5'd16;
    bus.RsAddr_ex = 5'd1; bus.RsData_ex = 32'h0000_FFFF;
    bus.RtAddr_ex = 5'd2; bus.RtData_ex = 32'h0001_0001;
    bus.RegDst_ex = 1'b1; bus.RdAddr_ex = 5'd9; bus.RegWrite_ex = 1'b1;
    #1;
    n = 0;
    bubbleErr = 0;
    while (bus.ex_busy && n < 100) begin
      n++;
      step();
      // Late WB traffic to the latched source must not alter the product
      bus.RegWrite_wb = 1'b1; bus.WriteAddr_wb = 5'd1; bus.WriteData_wb = 32'h1234_5678;
      #1;
      if (bus.ALUResult_mem != 0 || bus.RegWrite_mem || bus.WriteAddr_mem != 0 ||
          bus.MemWriteData_mem != 0)
        bubbleErr++;
    end
    checkVal("mulBusyCycles", n, 32'd33);
    checkVal("mulBubble", bubbleErr, 32'd0);
    step();
    checkVal("mulResult", bus.ALUResult_mem, 32'hFFFF_FFFF);
    checkVal("mulWaddr", {27'd0, bus.WriteAddr_mem}, 32'd9);
    checkVal("mulRegWrite", {31'd0, bus.RegWrite_mem}, 32'd1);

    // Reset during BUSY
    clearInputs();
    bus.ALUCode_ex = 5'd16;
    bus.RsData_ex = 32'd3; bus.RtData_ex = 32'd4; bus.RegWrite_ex = 1'b1;
    for (int i = 0; i < 11; i++) step();
    checkVal("mulMidBusy", {31'd0, bus.ex_busy}, 32'd1);
    reset = 1'b1;
    bus.ALUCode_ex = 5'd0;
    step();
    reset = 1'b0;
    checkVal("rstMidResult", bus.ALUResult_mem, 32'd0);
    checkVal("rstMidRegWrite", {31'd0, bus.RegWrite_mem}, 32'd0);
    checkVal("rstMidBusy", {31'd0, bus.ex_busy}, 32'd0);
    step();
    checkVal("postRstAdd", bus.ALUResult_mem, 32'd7);
`else
    // Without the multiplier code 16 is an undefined single-cycle op
    clearInputs();
    bus.ALUCode_ex = 5'd16;
    bus.RsData_ex = 32'd3; bus.RtData_ex = 32'd4; bus.RegWrite_ex = 1'b1;
    #1;
    checkVal("noMulBusy", {31'd0, bus.ex_busy}, 32'd0);
    step();
    checkVal("noMulResult", bus.ALUResult_mem, 32'd0);
    checkVal("noMulRegWrite", {31'd0, bus.RegWrite_mem}, 32'd1);
    checkVal("noMulBusyAfter", {31'd0, bus.ex_busy}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
